// File: rtl/gobou_ctrl_if.sv
// Handshake/bus bundle between the layer-config side, gobou_ctrl and the core/memories.
interface gobou_ctrl_if #(
  parameter int NWIDTH = 10,
  parameter int OWIDTH = 10,
  parameter int WWIDTH = 16
);
  logic              req;
  logic [NWIDTH-1:0] total_in;
  logic [OWIDTH-1:0] total_out;
  logic [WWIDTH-1:0] w_base;
  logic              busy;
  logic              ack;
  logic [NWIDTH-1:0] in_addr;
  logic [WWIDTH-1:0] w_addr;
  logic [OWIDTH-1:0] out_addr;
  logic              out_we;
  logic              accum_rst;
  logic              accum_we;
  logic              breg_we;
  logic              mac_oe;
  logic              bias_oe;
  logic              relu_oe;

  modport master (
    output req, total_in, total_out, w_base,
    input  busy, ack, in_addr, w_addr, out_addr, out_we,
           accum_rst, accum_we, breg_we, mac_oe, bias_oe, relu_oe
  );
  modport slave (
    input  req, total_in, total_out, w_base,
    output busy, ack, in_addr, w_addr, out_addr, out_we,
           accum_rst, accum_we, breg_we, mac_oe, bias_oe, relu_oe
  );
endinterface

// File: rtl/gobou_ctrl.sv
// Fully-connected layer sequencer for gobou_core: walks weight/input addresses,
// drives core strobes and writes each neuron result to the output buffer.
module gobou_ctrl #(
  parameter int NWIDTH = 10,
  parameter int OWIDTH = 10,
  parameter int WWIDTH = 16,
  parameter int MEMLAT = 1
) (
  input logic         clk,
  input logic         xrst,
  gobou_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_ACC, S_DRAIN, S_OUT, S_DONE} state_t;
  typedef struct packed {
    logic breg_we;
    logic accum_rst;
    logic accum_we;
  } core_stb_t;

  state_t              state;
  logic [NWIDTH-1:0]   n, i;
  logic [OWIDTH-1:0]   m, o;
  logic [WWIDTH-1:0]   w_ptr;
  logic [2:0]          j;
  core_stb_t [MEMLAT:0] stb_pipe;

  logic              busy_r, ack_r, out_we_r, mac_oe_r, bias_oe_r, relu_oe_r;
  logic [NWIDTH-1:0] in_addr_r;
  logic [WWIDTH-1:0] w_addr_r;
  logic [OWIDTH-1:0] out_addr_r;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state      <= S_IDLE;
      n          <= '0;
      i          <= '0;
      m          <= '0;
      o          <= '0;
      w_ptr      <= '0;
      j          <= '0;
      stb_pipe   <= '0;
      busy_r     <= 1'b0;
      ack_r      <= 1'b0;
      out_we_r   <= 1'b0;
      mac_oe_r   <= 1'b0;
      bias_oe_r  <= 1'b0;
      relu_oe_r  <= 1'b0;
      in_addr_r  <= '0;
      w_addr_r   <= '0;
      out_addr_r <= '0;
    end else begin
      stb_pipe[0] <= '0;
      ack_r       <= 1'b0;
      out_we_r    <= 1'b0;
      mac_oe_r    <= 1'b0;
      bias_oe_r   <= 1'b0;
      relu_oe_r   <= 1'b0;
      // Core strobes trail their address by MEMLAT so they meet the memory data.
      for (int k = 1; k <= MEMLAT; k++) stb_pipe[k] <= stb_pipe[k-1];
      case (state)
        S_IDLE: if (bus.req && !busy_r) begin
          n      <= bus.total_in;
          m      <= bus.total_out;
          w_ptr  <= bus.w_base;
          o      <= '0;
          i      <= '0;
          j      <= '0;
          busy_r <= 1'b1;
          state  <= (bus.total_out == '0) ? S_DONE : S_BIAS;
        end
        S_BIAS: begin
          w_addr_r              <= w_ptr;
          w_ptr                 <= w_ptr + WWIDTH'(1);
          stb_pipe[0].breg_we   <= 1'b1;
          stb_pipe[0].accum_rst <= 1'b1;
          i                     <= '0;
          j                     <= '0;
          state                 <= (n == '0) ? S_DRAIN : S_ACC;
        end
        S_ACC: begin
          w_addr_r             <= w_ptr;
          w_ptr                <= w_ptr + WWIDTH'(1);
          in_addr_r            <= i;
          stb_pipe[0].accum_we <= 1'b1;
          if (i == n - NWIDTH'(1)) state <= S_DRAIN;
          else                     i     <= i + NWIDTH'(1);
        end
        S_DRAIN: begin
          if (j == 3'(MEMLAT - 1)) begin
            j     <= '0;
            state <= S_OUT;
          end else j <= j + 3'd1;
        end
        S_OUT: begin
          case (j)
            3'd0:    mac_oe_r  <= 1'b1;
            3'd1:    bias_oe_r <= 1'b1;
            3'd2:    relu_oe_r <= 1'b1;
            default: begin
              out_we_r   <= 1'b1;
              out_addr_r <= o;
            end
          endcase
          if (j == 3'd3) begin
            j <= '0;
            if (o == m - OWIDTH'(1)) state <= S_DONE;
            else begin
              o     <= o + OWIDTH'(1);
              state <= S_BIAS;
            end
          end else j <= j + 3'd1;
        end
        S_DONE: begin
          ack_r <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // busy stays up through the ack cycle so a req there is still ignored.
      if (ack_r) busy_r <= 1'b0;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.ack       = ack_r;
  assign bus.in_addr   = in_addr_r;
  assign bus.w_addr    = w_addr_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_we    = out_we_r;
  assign bus.mac_oe    = mac_oe_r;
  assign bus.bias_oe   = bias_oe_r;
  assign bus.relu_oe   = relu_oe_r;
  assign bus.breg_we   = stb_pipe[MEMLAT].breg_we;
  assign bus.accum_rst = stb_pipe[MEMLAT].accum_rst;
  assign bus.accum_we  = stb_pipe[MEMLAT].accum_we;
endmodule

// File: tb/tb_gobou_ctrl.sv
// Scoreboard bench for gobou_ctrl: directed layers on a MEMLAT=1 and a MEMLAT=3 instance.
module tb_gobou_ctrl;
  logic clk = 1'b0;
  logic xrst = 1'b0;
  always #5 clk = ~clk;

  gobou_ctrl_if #(.NWIDTH(10), .OWIDTH(10), .WWIDTH(16)) bus ();
  gobou_ctrl_if #(.NWIDTH(10), .OWIDTH(10), .WWIDTH(16)) bus3 ();

  gobou_ctrl #(.NWIDTH(10), .OWIDTH(10), .WWIDTH(16), .MEMLAT(1)) u_dut (
    .clk(clk), .xrst(xrst), .bus(bus));
  gobou_ctrl #(.NWIDTH(10), .OWIDTH(10), .WWIDTH(16), .MEMLAT(3)) u_dut3 (
    .clk(clk), .xrst(xrst), .bus(bus3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int inst;
    bit is_ack;
    int addr;
    int cyc;
  } ev_t;
  ev_t sbq[$];

  int n_chk = 0, n_pass = 0;
  int n_acc = 0, n_breg = 0, n_rst = 0, n_mac = 0, n_bias = 0, n_relu = 0, n_oh = 0;
  int l_breg3 = 0, l_acc3 = 0, l_mac3 = 0, l_we3 = 0;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon_ev(int inst, bit is_ack, int addr);
    ev_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: inst%0d ack=%0b addr=%0d at cycle %0d, expected none",
               inst, is_ack, addr, cyc);
    end else begin
      e = sbq.pop_front();
      chk("ev_inst", inst, e.inst);
      chk("ev_kind", is_ack, e.is_ack);
      chk("ev_addr", addr, e.addr);
      chk("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every out_we/ack and tallies strobes.
  always @(negedge clk) if (xrst) begin
    if (bus.out_we)  mon_ev(0, 1'b0, int'(bus.out_addr));
    if (bus.ack)     mon_ev(0, 1'b1, 0);
    if (bus3.out_we) mon_ev(1, 1'b0, int'(bus3.out_addr));
    if (bus3.ack)    mon_ev(1, 1'b1, 0);
    n_acc  += int'(bus.accum_we);
    n_breg += int'(bus.breg_we);
    n_rst  += int'(bus.accum_rst);
    n_mac  += int'(bus.mac_oe);
    n_bias += int'(bus.bias_oe);
    n_relu += int'(bus.relu_oe);
    if ($countones({bus.mac_oe, bus.bias_oe, bus.relu_oe, bus.out_we}) > 1) n_oh++;
    if (bus3.breg_we)  l_breg3 = cyc;
    if (bus3.accum_we) l_acc3  = cyc;
    if (bus3.mac_oe)   l_mac3  = cyc;
    if (bus3.out_we)   l_we3   = cyc;
  end

  function automatic logic [63:0] outvec();
    return 64'({bus.busy, bus.ack, bus.out_we, bus.accum_rst, bus.accum_we, bus.breg_we,
                bus.mac_oe, bus.bias_oe, bus.relu_oe, bus.in_addr, bus.w_addr, bus.out_addr});
  endfunction

  // Issue a layer and push its expected out_we/ack events.
  task automatic do_req(int inst, int n, int m, int wb, int ml, output int rc);
    int p;
    @(posedge clk); #1;
    if (inst == 0) begin
      bus.total_in = 10'(n); bus.total_out = 10'(m); bus.w_base = 16'(wb); bus.req = 1'b1;
    end else begin
      bus3.total_in = 10'(n); bus3.total_out = 10'(m); bus3.w_base = 16'(wb); bus3.req = 1'b1;
    end
    rc = cyc;
    p = 5 + n + ml;
    for (int o = 0; o < m; o++) sbq.push_back('{inst, 1'b0, o, rc + (o + 1) * p + 1});
    sbq.push_back('{inst, 1'b1, 0, rc + m * p + 2});
    @(posedge clk); #1;
    bus.req = 1'b0;
    bus3.req = 1'b0;
  endtask

  task automatic drain(int budget);
    int k = 0;
    while (sbq.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("drain_pending_events", sbq.size(), 0);
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int rc, d;
    int b_acc, b_breg, b_rst, b_mac, b_bias, b_relu, b_oh;
    bus.req = 1'b0;  bus.total_in = '0;  bus.total_out = '0;  bus.w_base = '0;
    bus3.req = 1'b0; bus3.total_in = '0; bus3.total_out = '0; bus3.w_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outvec(), 0);
    @(posedge clk); #1 xrst = 1'b1;

    // N=3, M=2, w_base=100: address/strobe timing cycle by cycle
    b_acc = n_acc; b_breg = n_breg; b_mac = n_mac; b_oh = n_oh;
    do_req(0, 3, 2, 100, 1, rc);
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      d = cyc - rc;
      if (d >= 2 && d <= 5)   chk("w_addr_n0", bus.w_addr, 100 + d - 2);
      if (d >= 11 && d <= 14) chk("w_addr_n1", bus.w_addr, 104 + d - 11);
      if (d >= 3 && d <= 5)   chk("in_addr", bus.in_addr, d - 3);
      chk("accum_we_t", bus.accum_we, (d inside {4, 5, 6, 13, 14, 15}) ? 1 : 0);
      chk("breg_we_t", bus.breg_we, (d inside {3, 12}) ? 1 : 0);
    end
    drain(100);
    chk("t1_accum_cnt", n_acc - b_acc, 6);
    chk("t1_breg_cnt", n_breg - b_breg, 2);
    chk("t1_mac_cnt", n_mac - b_mac, 2);
    chk("t1_onehot", n_oh - b_oh, 0);

    // N=0, M=3: bias-only neurons
    b_acc = n_acc; b_breg = n_breg; b_rst = n_rst; b_relu = n_relu;
    do_req(0, 0, 3, 500, 1, rc);
    drain(100);
    chk("t2_accum_cnt", n_acc - b_acc, 0);
    chk("t2_breg_cnt", n_breg - b_breg, 3);
    chk("t2_rst_cnt", n_rst - b_rst, 3);
    chk("t2_relu_cnt", n_relu - b_relu, 3);
    chk("t2_w_addr", bus.w_addr, 502);

    // M=0: ack only
    b_acc = n_acc; b_breg = n_breg; b_rst = n_rst;
    b_mac = n_mac; b_bias = n_bias; b_relu = n_relu;
    do_req(0, 5, 0, 700, 1, rc);
    drain(50);
    chk("t3_strobes", (n_acc - b_acc) + (n_breg - b_breg) + (n_rst - b_rst) +
                      (n_mac - b_mac) + (n_bias - b_bias) + (n_relu - b_relu), 0);
    chk("t3_busy_after", bus.busy, 0);

    // req during busy is ignored
    b_acc = n_acc; b_breg = n_breg;
    do_req(0, 4, 1, 200, 1, rc);
    repeat (4) @(posedge clk);
    #1;
    bus.total_in = 10'd7; bus.total_out = 10'd5; bus.w_base = 16'd900; bus.req = 1'b1;
    @(negedge clk);
    chk("t4_busy_mid", bus.busy, 1);
    @(posedge clk); #1 bus.req = 1'b0;
    drain(100);
    chk("t4_accum_cnt", n_acc - b_acc, 4);
    chk("t4_breg_cnt", n_breg - b_breg, 1);
    chk("t4_w_addr", bus.w_addr, 204);
    repeat (20) @(posedge clk);

    // reset mid-S_ACC aborts the layer
    do_req(0, 8, 2, 0, 1, rc);
    repeat (3) @(posedge clk);
    #1 xrst = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_reset_outputs", outvec(), 0);
    @(posedge clk); #1 xrst = 1'b1;
    @(negedge clk);
    chk("t5_post_reset_outputs", outvec(), 0);
    repeat (40) @(posedge clk);
    chk("t5_idle_busy", bus.busy, 0);
    do_req(0, 2, 1, 50, 1, rc);
    drain(100);
    chk("t5_w_addr", bus.w_addr, 52);

    // MEMLAT=3, N=2, M=1 on the second instance
    do_req(1, 2, 1, 10, 3, rc);
    drain(100);
    chk("t6_breg_delay", l_breg3 - (rc + 2), 3);
    chk("t6_mac_after_acc", l_mac3 - l_acc3, 1);
    chk("t6_we_after_mac", l_we3 - l_mac3, 3);
    chk("t6_w_addr", bus3.w_addr, 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
